// File: rtl/median_axis_tx.sv
// ============================================================================
// median_axis_tx : FIFO-buffered AXI4-Stream master for the median pixel stream
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module median_axis_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic [LEN_W-1:0]              frame_len_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          valid_i,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          overflow_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int                c_aw      = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]     c_full    = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]     c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0]   c_ptr_one = c_aw'(1);
  localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [c_aw-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]       count_q, count_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d, len_q, len_d;
  logic                overflow_q, overflow_d;

  logic                w_accept, w_out_free, w_fifo_empty, w_fifo_full;
  logic                w_pop, w_bypass, w_load, w_push, w_drop, w_frame_start;
  logic [DATA_W-1:0]   w_head;
  logic [LEN_W-1:0]    w_len_in, w_len_eff;

  // The output register refills in the same cycle its beat is taken.
  assign w_accept     = tvalid_q & m_axis_tready;
  assign w_out_free   = ~tvalid_q | w_accept;
  assign w_fifo_empty = (count_q == '0);
  assign w_fifo_full  = (count_q == c_full);
  assign w_pop        = w_out_free & ~w_fifo_empty;
  assign w_bypass     = w_out_free & w_fifo_empty & valid_i;
  assign w_load       = w_pop | w_bypass;
  assign w_push       = valid_i & ~w_bypass & (~w_fifo_full | w_pop);
  assign w_drop       = valid_i & ~w_bypass & w_fifo_full & ~w_pop;
  assign w_head       = mem_q[rd_ptr_q];
  assign w_len_in     = (frame_len_i == '0) ? c_len_one : frame_len_i;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    beat_cnt_d    = beat_cnt_q;
    len_d         = len_q;
    overflow_d    = overflow_q;
    w_frame_start = (state_q == S_IDLE) | (w_accept & tlast_q);
    w_len_eff     = w_frame_start ? w_len_in : len_q;

    if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    if (w_accept) beat_cnt_d = tlast_q ? '0 : beat_cnt_q + c_len_one;

    if (w_accept & tlast_q) state_d = S_IDLE;
    if (w_load & w_frame_start) begin
      state_d = S_STREAM;
      len_d   = w_len_in;
    end

    // Framing flags are resolved for the beat index the loaded beat will own.
    if (w_load) begin
      tvalid_d = 1'b1;
      tdata_d  = w_fifo_empty ? data_i : w_head;
      tuser_d  = (beat_cnt_d == '0);
      tlast_d  = (beat_cnt_d == (w_len_eff - c_len_one));
    end else if (w_accept) begin
      tvalid_d = 1'b0;
    end

    if (clear_i) overflow_d = 1'b0;
    if (w_drop)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= c_len_one;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q == S_STREAM);
  assign fifo_level_o  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_median_axis_tx.sv
// ============================================================================
// tb_median_axis_tx : scoreboard bench for median_axis_tx
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_median_axis_tx;

  logic        clk = 1'b0;
  logic        rst, clear_i, valid_i, tready;
  logic [16:0] frame_len_i;
  logic [7:0]  data_i;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, overflow_o, busy_o;
  logic [4:0]  fifo_level_o;

  median_axis_tx #(.DATA_W(8), .FIFO_DEPTH(16), .LEN_W(17)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .frame_len_i(frame_len_i),
    .data_i(data_i), .valid_i(valid_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .overflow_o(overflow_o),
    .busy_o(busy_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic user; logic last; } beat_t;
  typedef struct { logic [16:0] flen; int nframes; int rmode; int exp_len; } vec_t;

  beat_t sb[$];
  vec_t  vecs[5];
  int    total = 0, bad = 0;
  int    rmode = 0;      // 0: tready=1, 1: random, 2: tready=0
  int    exp_len = 1, exp_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    valid_i = v;
    data_i  = d;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  endtask

  task automatic push_exp(input logic [7:0] d);
    beat_t e;
    e.data = d;
    e.user = (exp_idx == 0);
    e.last = (exp_idx == exp_len - 1);
    sb.push_back(e);
    exp_idx = (exp_idx == exp_len - 1) ? 0 : exp_idx + 1;
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d);
    push_exp(d);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 1000) begin
      tick(1'b0, 8'h00);
      g++;
    end
    check("drain_empty", sb.size(), 0);
    tick(1'b0, 8'h00);
    @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks stall stability.
  logic [7:0] prev_data;
  logic       prev_user, prev_last, stall_prev = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, prev_data);
        check("hold_tuser", m_axis_tuser, prev_user);
        check("hold_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          check("beat_tdata", m_axis_tdata, e.data);
          check("beat_tuser", m_axis_tuser, e.user);
          check("beat_tlast", m_axis_tlast, e.last);
        end
      end
      stall_prev = m_axis_tvalid && !tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{17'd49, 1, 0, 49};
    vecs[1] = '{17'd25, 3, 1, 25};
    vecs[2] = '{17'd0,  4, 0, 1};
    vecs[3] = '{17'd1,  4, 1, 1};
    vecs[4] = '{17'd7,  2, 1, 7};

    rst = 1'b1; clear_i = 1'b0; valid_i = 1'b0; tready = 1'b0;
    data_i = 8'h00; frame_len_i = 17'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_level", fifo_level_o, 0);

    // Single-sample latency through the bypass path
    rmode = 0; exp_len = 1; exp_idx = 0;
    send(8'hA5);
    tick(1'b0, 8'h00);
    @(negedge clk);
    check("lat_tvalid", m_axis_tvalid, 1);
    check("lat_tdata", m_axis_tdata, 8'hA5);
    check("lat_bypass_level", fifo_level_o, 0);
    check("lat_busy", busy_o, 1);
    tick(1'b0, 8'h00);
    @(negedge clk);
    check("lat_tvalid_after", m_axis_tvalid, 0);
    check("lat_busy_after", busy_o, 0);

    // Table-driven framing runs
    for (int v = 0; v < 5; v++) begin
      frame_len_i = vecs[v].flen;
      rmode       = vecs[v].rmode;
      exp_len     = vecs[v].exp_len;
      exp_idx     = 0;
      for (int n = 0; n < vecs[v].nframes * vecs[v].exp_len; n++) begin
        for (int g = 0; g < 200 && fifo_level_o >= 5'd12; g++) tick(1'b0, 8'h00);
        send(8'(n));
      end
      drain();
      check("tbl_busy_end", busy_o, 0);
      check("tbl_overflow", overflow_o, 0);
    end

    // Backpressure and overflow
    rmode = 2; frame_len_i = 17'd17; exp_len = 17; exp_idx = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(i));
      if (i <= 16) push_exp(8'(i));
    end
    tick(1'b0, 8'h00);
    @(negedge clk);
    check("bp_level", fifo_level_o, 16);
    check("bp_overflow", overflow_o, 1);
    check("bp_tdata", m_axis_tdata, 0);
    check("bp_tvalid", m_axis_tvalid, 1);
    rmode = 0;
    drain();
    repeat (3) tick(1'b0, 8'h00);
    @(negedge clk);
    check("bp_no_extra", m_axis_tvalid, 0);
    check("bp_overflow_sticky", overflow_o, 1);
    check("bp_busy_end", busy_o, 0);
    tick(1'b0, 8'h00);
    clear_i = 1'b1;
    tick(1'b0, 8'h00);
    clear_i = 1'b0;
    @(negedge clk);
    check("clear_overflow", overflow_o, 0);

    // Full FIFO with simultaneous push and pop
    rmode = 2; frame_len_i = 17'd27; exp_len = 27; exp_idx = 0;
    for (int i = 0; i < 17; i++) send(8'(100 + i));
    tick(1'b0, 8'h00);
    @(negedge clk);
    check("full_level", fifo_level_o, 16);
    check("full_overflow", overflow_o, 0);
    rmode = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'(117 + i));
      @(negedge clk);
      check("full_pp_level", fifo_level_o, 16);
    end
    tick(1'b0, 8'h00);
    @(negedge clk);
    check("full_pp_overflow", overflow_o, 0);
    drain();
    check("full_busy_end", busy_o, 0);

    // frame_len_i changed mid-frame takes effect on the next frame only
    rmode = 0; frame_len_i = 17'd10; exp_len = 10; exp_idx = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'(40 + i));
      if (i == 3) frame_len_i = 17'd4;
    end
    exp_len = 4;
    for (int i = 0; i < 4; i++) send(8'(50 + i));
    drain();
    check("len_chg_busy_end", busy_o, 0);

    // Reset mid-frame
    rmode = 0; frame_len_i = 17'd10; exp_len = 10; exp_idx = 0;
    for (int i = 0; i < 5; i++) send(8'(60 + i));
    rmode = 2;
    for (int i = 0; i < 3; i++) send(8'(65 + i));
    tick(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_tuser", m_axis_tuser, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_level", fifo_level_o, 0);
    sb.delete();
    exp_idx = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rmode = 0;
    for (int i = 0; i < 10; i++) send(8'(70 + i));
    drain();
    check("post_rst_busy_end", busy_o, 0);
    check("post_rst_overflow", overflow_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/median_axis_tx.md
# median_axis_tx

AXI4-Stream transmitter on the output side of the median filter path. It takes the filter's valid-only pixel stream, which has no backpressure and issues one pulse per output pixel. It buffers the pixels in a small FIFO and re-emits them as an AXI4-Stream master with full tvalid/tready handshake. It frames the output with tuser on the first pixel and tlast on the last pixel of each frame, so a DMA or downstream IP can consume any of the 3x3/5x5/7x7 median outputs.

## Interface
- DATA_W, 8, pixel width
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2
- LEN_W, 17, width of frame length field
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- clear_i  input  1  synchronous; clears overflow_o only
- frame_len_i  input  LEN_W  pixels per output frame; 0 is treated as 1
- data_i  input  DATA_W  filtered pixel (e.g. m_3x3_o)
- valid_i  input  1  data_i qualifier (e.g. m_3x3_valid_o); no ready returned
- m_axis_tdata  output  DATA_W  output pixel
- m_axis_tvalid  output  1  beat valid
- m_axis_tready  input  1  sink ready
- m_axis_tlast  output  1  last beat of frame
- m_axis_tuser  output  1  first beat of frame (start-of-frame)
- overflow_o  output  1  sticky: at least one input sample dropped
- busy_o  output  1  frame in flight
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, excluding the output register

## Operation
- Storage consists of a FIFO_DEPTH-entry FIFO followed by a one-beat output register driving m_axis_*. Total capacity is FIFO_DEPTH+1 beats.
- Output register empty: it loads the FIFO head if the FIFO is non-empty, otherwise it loads data_i directly (bypass).
- Output register holding a beat that is accepted (tvalid & tready): it reloads the same cycle from the FIFO head or bypass, so a stream with tready held at 1 sustains 1 beat/cycle.
- Push: valid_i is accepted when the FIFO is not full, or when it is full but a pop occurs in the same cycle. Otherwise the sample is dropped and overflow_o is set.
- overflow_o stays at 1 until rst, or until clear_i is sampled high. If clear_i and a new drop occur in the same cycle, the set wins.
- AXI rules: while tvalid=1 and tready=0, tdata, tlast and tuser are held stable and tvalid does not fall. tvalid never depends combinationally on tready.
- Beat counter beat_cnt[LEN_W-1:0] increments on each accepted beat.
- tuser is 1 on the beat with beat_cnt==0.
- tlast is 1 on the beat with beat_cnt==len_q-1. beat_cnt wraps to 0 on the accepted tlast beat.
- FSM has two states:
  - IDLE: beat_cnt=0. On the first load of the output register, len_q latches max(frame_len_i,1) and the FSM goes to STREAM.
  - STREAM: on an accepted tlast beat, the FSM returns to IDLE. It re-enters STREAM in the same cycle if the next beat is loaded in that cycle.
- Changes to frame_len_i during STREAM are ignored until the next frame.
- busy_o = (state==STREAM).
- Frames are delimited only by count. Pixel order is preserved exactly.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0
  - overflow_o=0, busy_o=0, fifo_level_o=0
  - FIFO empty, beat_cnt=0, len_q=1, state IDLE
- Latency: with the pipe empty, a sample accepted at rising edge k has m_axis_tvalid=1 with that data after edge k. It is visible for one cycle and acceptable at edge k+1.
- fifo_level_o updates the cycle after each push or pop.
- Full FIFO with simultaneous push and pop: the level is unchanged and nothing is dropped.
- Empty FIFO with the output register free: the sample bypasses the FIFO and the level stays 0.
- Reset mid-frame: all stored beats are discarded. The next sample after reset deassertion is tuser=1 of a new frame.
- tlast and tuser are both 1 on the single beat when len_q==1.

## Test plan
- Single frame: frame_len_i=49 (3x3 on 9x9), 49 back-to-back samples 0..48, tready=1. Required: 49 beats in order, tuser only on data 0, tlast only on data 48, busy_o low after the last beat, overflow_o=0.
- Backpressure/overflow: DEPTH=16, tready=0, 20 samples 0..19. Required: fifo_level_o=16, overflow_o=1, and tdata held at 0. Then tready=1: beats 0..16 delivered in order, 17..19 absent. Pulsing clear_i then drops overflow_o to 0.
- Full FIFO: fill FIFO and output register, then drive valid_i with tready=1 each cycle for 10 cycles. Required: no drop, overflow_o stays 0, level stays 16.
- Random tready (50%) over 3 frames of frame_len_i=25. Required: 75 beats in order, tuser on beats 0/25/50, tlast on 24/49/74, tdata stable whenever stalled.
- frame_len_i=0 and =1: every beat has tuser=1 and tlast=1. Changing frame_len_i from 10 to 4 at beat 3 still ends that frame at beat 9.
- Assert rst at beat 5 of a frame_len_i=10 frame. Required: outputs at reset values immediately. After release, the next sample is emitted with tuser=1, and tlast falls at the 10th beat.
